// File: rtl/rv32i_types_pkg.sv
// Shared RV32I types: the reorder-buffer entry record and the major opcode constants.
package rv32i_types;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [31:0] val;
    logic        br_en;
    logic [31:0] br_target;
    logic        done;
  } rob_entry_t;

  function automatic logic is_ctrl_op(input logic [6:0] op);
    return (op == OP_BR) || (op == OP_JAL) || (op == OP_JALR);
  endfunction

endpackage

// File: rtl/rob_commit_sel.sv
// Combinational in-order retirement slot selection for the reorder buffer.
module rob_commit_sel #(
  parameter int DEPTH    = 16,
  parameter int COMMIT_W = 2,
  parameter int TAG_W    = 4,
  parameter int NC_W     = 2
) (
  input  logic [TAG_W-1:0]                head_idx,
  input  logic [DEPTH-1:0]                alloc,
  input  logic [DEPTH-1:0]                done,
  input  logic [DEPTH-1:0]                is_ctrl,
  input  logic                            commit_hold,
  input  logic                            flush,
  output logic [COMMIT_W-1:0]             commit_valid,
  output logic [COMMIT_W-1:0][TAG_W-1:0]  commit_idx,
  output logic [NC_W-1:0]                 num_commit
);

  logic chain;
  logic prev_ctrl;

  // A slot stays valid only while every earlier slot is valid and none of them was a control transfer.
  always_comb begin
    chain        = !commit_hold && !flush;
    prev_ctrl    = 1'b0;
    num_commit   = '0;
    commit_valid = '0;
    commit_idx   = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      commit_idx[k]   = head_idx + TAG_W'(k);
      chain           = chain && !prev_ctrl && alloc[commit_idx[k]] && done[commit_idx[k]];
      commit_valid[k] = chain;
      if (chain) num_commit = num_commit + NC_W'(1);
      prev_ctrl       = is_ctrl[commit_idx[k]];
    end
  end

endmodule

// File: rtl/rob_nway.sv
// N-way reorder buffer: dispatch at tail, multi-port CDB writeback, up to COMMIT_W in-order retirements.
// Optional macro ROB_CDB_BYPASS_EN forwards same-cycle CDB writes to the operand lookup ports.
module rob_nway
  import rv32i_types::*;
#(
  parameter int DEPTH    = 16,
  parameter int NUM_CDB  = 4,
  parameter int COMMIT_W = 2,
  localparam int TAG_W   = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        disp_valid,
  output logic                        disp_ready,
  input  logic [6:0]                  disp_opcode,
  input  logic [4:0]                  disp_rd,
  output logic [TAG_W-1:0]            disp_tag,
  input  logic [NUM_CDB-1:0]          cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]    cdb_tag,
  input  logic [NUM_CDB*32-1:0]       cdb_val,
  input  logic [NUM_CDB*32-1:0]       cdb_br_target,
  input  logic [NUM_CDB-1:0]          cdb_br_en,
  input  logic [2*TAG_W-1:0]          rs_tag,
  output logic [1:0]                  rs_ready,
  output logic [63:0]                 rs_val,
  input  logic                        commit_hold,
  output logic [COMMIT_W-1:0]         commit_valid,
  output rob_entry_t [COMMIT_W-1:0]   commit_entry,
  output logic [COMMIT_W*TAG_W-1:0]   commit_tag,
  output logic [TAG_W:0]              count,
  output logic                        empty,
  output logic                        full
);

  localparam int NC_W = (COMMIT_W > 1) ? 2 : 1;

  logic [TAG_W:0]   head_q, head_d, tail_q, tail_d;
  logic [DEPTH-1:0] alloc_q, alloc_d, done_q, done_d;
  logic [DEPTH-1:0] ctrl_vec, cdb_hit;
  logic [6:0]       opcode_q [DEPTH];
  logic [6:0]       opcode_d [DEPTH];
  logic [4:0]       rd_q [DEPTH];
  logic [4:0]       rd_d [DEPTH];
  logic [31:0]      val_q [DEPTH];
  logic [31:0]      val_d [DEPTH];
  logic             br_en_q [DEPTH];
  logic             br_en_d [DEPTH];
  logic [31:0]      br_tgt_q [DEPTH];
  logic [31:0]      br_tgt_d [DEPTH];

  logic [TAG_W-1:0]                tail_idx;
  logic                            disp_fire;
  logic [COMMIT_W-1:0][TAG_W-1:0]  commit_idx;
  logic [NC_W-1:0]                 num_commit;

  assign tail_idx   = tail_q[TAG_W-1:0];
  assign count      = tail_q - head_q;
  assign empty      = (count == '0);
  assign full       = (count == (TAG_W+1)'(DEPTH));
  assign disp_ready = !full;
  assign disp_tag   = tail_idx;
  assign disp_fire  = disp_valid && disp_ready && !flush;

  always_comb begin
    for (int e = 0; e < DEPTH; e++) ctrl_vec[e] = is_ctrl_op(opcode_q[e]);
  end

  rob_commit_sel #(
    .DEPTH    (DEPTH),
    .COMMIT_W (COMMIT_W),
    .TAG_W    (TAG_W),
    .NC_W     (NC_W)
  ) u_commit_sel (
    .head_idx     (head_q[TAG_W-1:0]),
    .alloc        (alloc_q),
    .done         (done_q),
    .is_ctrl      (ctrl_vec),
    .commit_hold  (commit_hold),
    .flush        (flush),
    .commit_valid (commit_valid),
    .commit_idx   (commit_idx),
    .num_commit   (num_commit)
  );

  // Entry payload: dispatch fields at tail, CDB writeback with the highest-index port winning.
  always_comb begin
    opcode_d = opcode_q;
    rd_d     = rd_q;
    val_d    = val_q;
    br_en_d  = br_en_q;
    br_tgt_d = br_tgt_q;
    cdb_hit  = '0;
    if (disp_fire) begin
      opcode_d[tail_idx] = disp_opcode;
      rd_d[tail_idx]     = disp_rd;
    end
    for (int p = 0; p < NUM_CDB; p++) begin
      if (cdb_valid[p] && !flush && alloc_q[cdb_tag[p*TAG_W +: TAG_W]]) begin
        val_d[cdb_tag[p*TAG_W +: TAG_W]]    = cdb_val[p*32 +: 32];
        br_en_d[cdb_tag[p*TAG_W +: TAG_W]]  = cdb_br_en[p];
        br_tgt_d[cdb_tag[p*TAG_W +: TAG_W]] = cdb_br_target[p*32 +: 32];
        cdb_hit[cdb_tag[p*TAG_W +: TAG_W]]  = 1'b1;
      end
    end
  end

  always_comb begin
    head_d  = head_q + (TAG_W+1)'(num_commit);
    tail_d  = tail_q + (TAG_W+1)'(disp_fire);
    alloc_d = alloc_q;
    done_d  = done_q | cdb_hit;
    for (int k = 0; k < COMMIT_W; k++) begin
      if (commit_valid[k]) begin
        alloc_d[commit_idx[k]] = 1'b0;
        done_d[commit_idx[k]]  = 1'b0;
      end
    end
    if (disp_fire) begin
      alloc_d[tail_idx] = 1'b1;
      done_d[tail_idx]  = 1'b0;
    end
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      alloc_d = '0;
      done_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      alloc_q <= '0;
      done_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      alloc_q <= alloc_d;
      done_q  <= done_d;
    end
  end

  // Payload is qualified by alloc/done, so it needs no reset.
  always_ff @(posedge clk) begin
    opcode_q <= opcode_d;
    rd_q     <= rd_d;
    val_q    <= val_d;
    br_en_q  <= br_en_d;
    br_tgt_q <= br_tgt_d;
  end

  always_comb begin
    commit_entry = '0;
    commit_tag   = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      commit_tag[k*TAG_W +: TAG_W]  = commit_idx[k];
      commit_entry[k].opcode        = opcode_q[commit_idx[k]];
      commit_entry[k].rd            = rd_q[commit_idx[k]];
      commit_entry[k].val           = val_q[commit_idx[k]];
      commit_entry[k].br_en         = br_en_q[commit_idx[k]];
      commit_entry[k].br_target     = br_tgt_q[commit_idx[k]];
      commit_entry[k].done          = done_q[commit_idx[k]];
    end
  end

  always_comb begin
    rs_ready = '0;
    rs_val   = '0;
    for (int i = 0; i < 2; i++) begin
      rs_ready[i]        = alloc_q[rs_tag[i*TAG_W +: TAG_W]] && done_q[rs_tag[i*TAG_W +: TAG_W]];
      rs_val[i*32 +: 32] = val_q[rs_tag[i*TAG_W +: TAG_W]];
`ifdef ROB_CDB_BYPASS_EN
      for (int p = 0; p < NUM_CDB; p++) begin
        if (cdb_valid[p] && (cdb_tag[p*TAG_W +: TAG_W] == rs_tag[i*TAG_W +: TAG_W]) &&
            alloc_q[rs_tag[i*TAG_W +: TAG_W]]) begin
          rs_ready[i]        = 1'b1;
          rs_val[i*32 +: 32] = cdb_val[p*32 +: 32];
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_rob_nway.sv
// Directed self-checking bench for rob_nway (default parameters; honours ROB_CDB_BYPASS_EN).
module tb_rob_nway;
  import rv32i_types::*;

  localparam int DEPTH    = 16;
  localparam int NUM_CDB  = 4;
  localparam int COMMIT_W = 2;
  localparam int TAG_W    = 4;

  logic                       clk;
  logic                       rst_n;
  logic                       flush;
  logic                       disp_valid;
  logic                       disp_ready;
  logic [6:0]                 disp_opcode;
  logic [4:0]                 disp_rd;
  logic [TAG_W-1:0]           disp_tag;
  logic [NUM_CDB-1:0]         cdb_valid;
  logic [NUM_CDB*TAG_W-1:0]   cdb_tag;
  logic [NUM_CDB*32-1:0]      cdb_val;
  logic [NUM_CDB*32-1:0]      cdb_br_target;
  logic [NUM_CDB-1:0]         cdb_br_en;
  logic [2*TAG_W-1:0]         rs_tag;
  logic [1:0]                 rs_ready;
  logic [63:0]                rs_val;
  logic                       commit_hold;
  logic [COMMIT_W-1:0]        commit_valid;
  rob_entry_t [COMMIT_W-1:0]  commit_entry;
  logic [COMMIT_W*TAG_W-1:0]  commit_tag;
  logic [TAG_W:0]             count;
  logic                       empty;
  logic                       full;

  int errors = 0;
  int checks = 0;

  rob_nway #(
    .DEPTH    (DEPTH),
    .NUM_CDB  (NUM_CDB),
    .COMMIT_W (COMMIT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .disp_valid    (disp_valid),
    .disp_ready    (disp_ready),
    .disp_opcode   (disp_opcode),
    .disp_rd       (disp_rd),
    .disp_tag      (disp_tag),
    .cdb_valid     (cdb_valid),
    .cdb_tag       (cdb_tag),
    .cdb_val       (cdb_val),
    .cdb_br_target (cdb_br_target),
    .cdb_br_en     (cdb_br_en),
    .rs_tag        (rs_tag),
    .rs_ready      (rs_ready),
    .rs_val        (rs_val),
    .commit_hold   (commit_hold),
    .commit_valid  (commit_valid),
    .commit_entry  (commit_entry),
    .commit_tag    (commit_tag),
    .count         (count),
    .empty         (empty),
    .full          (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    flush         = 1'b0;
    disp_valid    = 1'b0;
    commit_hold   = 1'b0;
    cdb_valid     = '0;
    cdb_br_en     = '0;
    cdb_br_target = '0;
  endtask

  task automatic cdb_w(input int p, input logic [TAG_W-1:0] t, input logic [31:0] v);
    cdb_valid[p]            = 1'b1;
    cdb_tag[p*TAG_W +: TAG_W] = t;
    cdb_val[p*32 +: 32]     = v;
  endtask

  initial begin
    idle();
    cdb_tag     = '0;
    cdb_val     = '0;
    rs_tag      = '0;
    disp_opcode = OP_REG;
    disp_rd     = '0;
    rst_n       = 1'b0;
    #12;
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_disp_ready", disp_ready, 1);
    chk("rst_disp_tag", disp_tag, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Fill to full, then show a same-cycle commit does not let dispatch in.
    for (int i = 0; i < 16; i++) begin
      disp_valid = 1'b1;
      disp_rd    = 5'(i);
      settle();
      chk("fill_tag", disp_tag, 64'(i));
      tick();
    end
    settle();
    chk("fill_full", full, 1);
    chk("fill_ready", disp_ready, 0);
    chk("fill_count", count, 16);
    tick();
    settle();
    chk("fill_17th_blocked", count, 16);
    cdb_w(0, 4'd0, 32'h5);
    tick();
    cdb_valid = '0;
    settle();
    chk("full_commit_valid", commit_valid, 2'b01);
    chk("full_commit_ready", disp_ready, 0);
    tick();
    settle();
    chk("full_no_reuse_count", count, 15);
    disp_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    settle();
    chk("fill_flush_count", count, 0);

    // Out-of-order writeback, CDB priority, commit_hold.
    disp_opcode = OP_REG;
    disp_valid  = 1'b1;
    tick(); tick(); tick();
    disp_valid  = 1'b0;
    commit_hold = 1'b1;
    cdb_w(0, 4'd2, 32'h22);
    tick();
    cdb_valid = '0;
    cdb_w(1, 4'd0, 32'h100);
    tick();
    cdb_valid = '0;
    cdb_w(0, 4'd1, 32'hAAA);
    cdb_w(2, 4'd1, 32'h111);
    settle();
    chk("hold_blocks", commit_valid, 0);
    tick();
    cdb_valid   = '0;
    commit_hold = 1'b0;
    settle();
    chk("ooo_two_valid", commit_valid, 2'b11);
    chk("ooo_two_tags", commit_tag, 8'h10);
    chk("ooo_slot0_val", commit_entry[0].val, 32'h100);
    chk("cdb_prio_val", commit_entry[1].val, 32'h111);
    tick();
    settle();
    chk("ooo_last_valid", commit_valid, 2'b01);
    chk("ooo_last_tag", commit_tag[3:0], 2);
    chk("ooo_last_val", commit_entry[0].val, 32'h22);
    tick();
    settle();
    chk("ooo_empty", empty, 1);

    // Branch limit: jal in slot 0 blocks slot 1.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    disp_opcode = OP_JAL;
    disp_valid  = 1'b1;
    tick();
    disp_opcode = OP_REG;
    tick();
    disp_valid  = 1'b0;
    commit_hold = 1'b1;
    cdb_w(0, 4'd0, 32'h40);
    cdb_w(1, 4'd1, 32'h41);
    tick();
    cdb_valid   = '0;
    commit_hold = 1'b0;
    settle();
    chk("br_only_slot0", commit_valid, 2'b01);
    chk("br_slot0_tag", commit_tag[3:0], 0);
    chk("br_slot0_op", commit_entry[0].opcode, OP_JAL);
    tick();
    settle();
    chk("br_next_valid", commit_valid, 2'b01);
    chk("br_next_tag", commit_tag[3:0], 1);
    tick();

    // Unallocated write ignored, then bypass behaviour.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    cdb_w(0, 4'd4, 32'h55);
    tick();
    cdb_valid  = '0;
    disp_valid = 1'b1;
    tick(); tick(); tick(); tick(); tick();
    disp_valid = 1'b0;
    rs_tag = {4'd3, 4'd4};
    settle();
    chk("unalloc_ignored", rs_ready, 2'b00);
    cdb_w(0, 4'd4, 32'h1);
    cdb_w(3, 4'd4, 32'hDEADBEEF);
    settle();
`ifdef ROB_CDB_BYPASS_EN
    chk("byp_same_ready", rs_ready, 2'b01);
    chk("byp_same_val", rs_val[31:0], 32'hDEADBEEF);
`else
    chk("nobyp_same_ready", rs_ready, 2'b00);
`endif
    tick();
    cdb_valid = '0;
    settle();
    chk("byp_next_ready", rs_ready, 2'b01);
    chk("byp_next_val", rs_val[31:0], 32'hDEADBEEF);

    // Flush with five live entries, together with dispatch and CDB write.
    commit_hold = 1'b1;
    cdb_w(0, 4'd0, 32'h7);
    tick();
    cdb_valid   = '0;
    commit_hold = 1'b0;
    flush       = 1'b1;
    disp_valid  = 1'b1;
    cdb_w(1, 4'd1, 32'h9);
    settle();
    chk("flush_commit_blocked", commit_valid, 0);
    tick();
    idle();
    settle();
    chk("flush_count", count, 0);
    chk("flush_empty", empty, 1);
    chk("flush_dealloc", rs_ready, 2'b00);

    // Wrap through the pointer MSB.
    for (int i = 0; i < 40; i++) begin
      disp_valid = 1'b1;
      settle();
      chk("wrap_disp_tag", disp_tag, 64'(i % 16));
      tick();
      disp_valid = 1'b0;
      settle();
      chk("wrap_count", count, 1);
      cdb_w(0, 4'(i % 16), 32'(i));
      tick();
      cdb_valid = '0;
      settle();
      chk("wrap_commit_tag", {commit_valid, commit_tag[3:0]}, {2'b01, 4'(i % 16)});
      tick();
      settle();
      chk("wrap_empty_full", {empty, full}, 2'b10);
    end

    // Asynchronous reset in the middle of traffic.
    disp_valid = 1'b1;
    tick(); tick();
    disp_valid = 1'b0;
    cdb_w(0, 4'd8, 32'h88);
    #1;
    rst_n = 1'b0;
    settle();
    chk("mid_rst_count", count, 0);
    chk("mid_rst_status", {empty, full, disp_ready}, 3'b101);
    chk("mid_rst_commit", commit_valid, 0);
    chk("mid_rst_disp_tag", disp_tag, 0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    rs_tag = {4'd9, 4'd8};
    settle();
    chk("mid_rst_discard", rs_ready, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
